// File: rtl/microwave_datapath.sv
// microwave_datapath: countdown timer, heat-level PWM and end-of-cook beeper
// sitting behind the microwave controller's enable interface.
// Optional feature macro: MICROWAVE_DATAPATH_BEEP_EN (builds the beep divider).
module microwave_datapath #(
  parameter int TICKS_PER_SEC = 50_000_000,
  parameter int PWM_PERIOD    = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enDuration,
  input  logic        enHeatingLevel,
  input  logic        enOut,
  input  logic        enEnd,
  input  logic        enReset,
  input  logic [15:0] inDuration,
  input  logic [1:0]  inHeatLevel,
  output logic        doneCount,
  output logic [15:0] timeLeft,
  output logic        heaterOn,
  output logic        running,
  output logic        beep
);

  localparam int PRESC_W = $clog2(TICKS_PER_SEC);
  localparam int PWM_W   = $clog2(PWM_PERIOD);
  localparam int DUTY_W  = PWM_W + 1;

  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICKS_PER_SEC - 1);
  localparam logic [PWM_W-1:0]   PWM_LAST   = PWM_W'(PWM_PERIOD - 1);
  localparam logic [DUTY_W-1:0]  DUTY_HIGH  = DUTY_W'(PWM_PERIOD);
  localparam logic [DUTY_W-1:0]  DUTY_NORM  = DUTY_W'((PWM_PERIOD / 4) * 3);
  localparam logic [DUTY_W-1:0]  DUTY_MED   = DUTY_W'(PWM_PERIOD / 2);
  localparam logic [DUTY_W-1:0]  DUTY_LOW   = DUTY_W'(PWM_PERIOD / 4);

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    RUN,
    PAUSE,
    EXPIRED
  } state_t;

  state_t               state_reg, state_next;
  logic [15:0]          count_reg, count_next;
  logic [1:0]           level_reg, level_next;
  logic [PRESC_W-1:0]   presc_reg, presc_next;
  logic [PWM_W-1:0]     pwm_reg, pwm_next;
  logic                 done_reg, done_next;
  logic [DUTY_W-1:0]    duty;

  // State register; external reset clears everything, controller clear is
  // folded into the next-state logic so both behave identically.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= IDLE;
      count_reg <= '0;
      level_reg <= '0;
      presc_reg <= '0;
      pwm_reg   <= '0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      level_reg <= level_next;
      presc_reg <= presc_next;
      pwm_reg   <= pwm_next;
      done_reg  <= done_next;
    end
  end

  // Next-state logic: controller clear, then loads, then state transitions.
  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    level_next = level_reg;
    presc_next = presc_reg;
    pwm_next   = pwm_reg;
    done_next  = done_reg;
    if (enReset) begin
      state_next = IDLE;
      count_next = '0;
      level_next = '0;
      presc_next = '0;
      pwm_next   = '0;
      done_next  = 1'b0;
    end else begin
      if (enHeatingLevel) begin
        level_next = inHeatLevel;
      end
      // Duration loads only before cooking starts; the controller keeps
      // enDuration asserted through auto segments, so later loads are dropped.
      if (enDuration && (state_reg == IDLE || state_reg == ARMED)) begin
        count_next = inDuration;
        presc_next = '0;
        state_next = ARMED;
      end else begin
        case (state_reg)
          ARMED: begin
            if (enOut) begin
              if (count_reg != 16'd0) begin
                state_next = RUN;
              end else begin
                state_next = EXPIRED;
                done_next  = 1'b1;
              end
            end
          end
          RUN: begin
            pwm_next = (pwm_reg == PWM_LAST) ? '0 : pwm_reg + PWM_W'(1);
            if (presc_reg == PRESC_LAST) begin
              presc_next = '0;
              if (count_reg <= 16'd1) begin
                count_next = '0;
                state_next = EXPIRED;
                done_next  = 1'b1;
              end else begin
                count_next = count_reg - 16'd1;
                if (!enOut) begin
                  state_next = PAUSE;
                end
              end
            end else begin
              presc_next = presc_reg + PRESC_W'(1);
              if (!enOut) begin
                state_next = PAUSE;
              end
            end
          end
          PAUSE: begin
            if (enOut) begin
              state_next = RUN;
            end
          end
          EXPIRED: begin
            count_next = '0;
            done_next  = 1'b1;
          end
          default: begin
            state_next = IDLE;
          end
        endcase
      end
    end
  end

  // Heat level to PWM duty (cycles high per period).
  always_comb begin
    duty = DUTY_LOW;
    case (level_reg)
      2'd3:    duty = DUTY_HIGH;
      2'd2:    duty = DUTY_NORM;
      2'd1:    duty = DUTY_MED;
      default: duty = DUTY_LOW;
    endcase
  end

  // Outputs depend only on registered state.
  assign running   = (state_reg == RUN);
  assign heaterOn  = (state_reg == RUN) && ({1'b0, pwm_reg} < duty);
  assign timeLeft  = count_reg;
  assign doneCount = done_reg;

`ifdef MICROWAVE_DATAPATH_BEEP_EN
  localparam int BEEP_Q = TICKS_PER_SEC / 4;
  localparam int BEEP_W = $clog2(BEEP_Q) + 1;
  localparam logic [BEEP_W-1:0] BEEP_LAST = BEEP_W'(BEEP_Q - 1);

  logic [BEEP_W-1:0] beep_div_reg;
  logic              beep_reg;
  logic              beep_active_reg;

  // Beeper: starts high on entering the end-of-cook condition, then toggles
  // every quarter second; any exit from that condition silences it.
  always_ff @(posedge clock) begin
    if (reset || enReset || !(state_reg == EXPIRED && enEnd)) begin
      beep_div_reg    <= '0;
      beep_reg        <= 1'b0;
      beep_active_reg <= 1'b0;
    end else if (!beep_active_reg) begin
      beep_div_reg    <= '0;
      beep_reg        <= 1'b1;
      beep_active_reg <= 1'b1;
    end else if (beep_div_reg == BEEP_LAST) begin
      beep_div_reg <= '0;
      beep_reg     <= ~beep_reg;
    end else begin
      beep_div_reg <= beep_div_reg + BEEP_W'(1);
    end
  end

  assign beep = beep_reg;
`else
  logic unused_en_end;
  assign unused_en_end = enEnd;
  assign beep          = 1'b0;
`endif

endmodule

// File: tb/tb_microwave_datapath.sv
// tb_microwave_datapath: directed vector table plus hand-written countdown,
// pause/resume, PWM duty and beeper sequences for microwave_datapath.
module tb_microwave_datapath;

  logic        clock = 1'b0;
  logic        reset;
  logic        enDuration, enHeatingLevel, enOut, enEnd, enReset;
  logic [15:0] inDuration;
  logic [1:0]  inHeatLevel;
  logic        doneCount, heaterOn, running, beep;
  logic [15:0] timeLeft;

  int n_cmp  = 0;
  int n_fail = 0;

  // Bench model for the run sequences: 0 run, 1 pause, 2 expired.
  int m_state;
  int m_k;
  int m_dur;
  int m_lvl;

  microwave_datapath #(.TICKS_PER_SEC(10), .PWM_PERIOD(4)) dut (
    .clock(clock), .reset(reset),
    .enDuration(enDuration), .enHeatingLevel(enHeatingLevel),
    .enOut(enOut), .enEnd(enEnd), .enReset(enReset),
    .inDuration(inDuration), .inHeatLevel(inHeatLevel),
    .doneCount(doneCount), .timeLeft(timeLeft),
    .heaterOn(heaterOn), .running(running), .beep(beep)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        en_dur;
    logic        en_lvl;
    logic        en_out;
    logic        en_rst;
    logic [15:0] dur;
    logic [1:0]  lvl;
    logic [15:0] tl;
    logic        done;
    logic        run;
    logic        heat;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic int duty_of(input int lvl);
    case (lvl)
      3:       return 4;
      2:       return 3;
      1:       return 2;
      default: return 1;
    endcase
  endfunction

  // One cycle of a run sequence, checked against the bench model.
  task automatic cyc(input logic e, input logic ld, input logic [1:0] lvl);
    int exp_tl;
    enOut          = e;
    enHeatingLevel = ld;
    inHeatLevel    = lvl;
    @(posedge clock);
    if (ld) m_lvl = int'(lvl);
    if (m_state == 0) begin
      m_k++;
      if (m_k == m_dur * 10) m_state = 2;
      else if (!e) m_state = 1;
    end else if (m_state == 1 && e) begin
      m_state = 0;
    end
    #1;
    exp_tl = (m_state == 2) ? 0 : m_dur - m_k / 10;
    $display("cyc k=%0d enOut=%0b tl=%0d done=%0b run=%0b heat=%0b",
             m_k, e, timeLeft, doneCount, running, heaterOn);
    check("run_timeLeft", int'(timeLeft), exp_tl);
    check("run_done", int'(doneCount), (m_state == 2) ? 1 : 0);
    check("run_running", int'(running), (m_state == 0) ? 1 : 0);
    check("run_heater", int'(heaterOn),
          (m_state == 0 && (m_k % 4) < duty_of(m_lvl)) ? 1 : 0);
  endtask

  // Clear, load duration and level, then enter RUN.
  task automatic start_run(input int dur, input int lvl);
    enOut = 1'b0; enEnd = 1'b0; enDuration = 1'b0; enHeatingLevel = 1'b0;
    enReset = 1'b1;
    step();
    enReset        = 1'b0;
    enDuration     = 1'b1;
    inDuration     = 16'(dur);
    enHeatingLevel = 1'b1;
    inHeatLevel    = 2'(lvl);
    step();
    check("load_timeLeft", int'(timeLeft), dur);
    enDuration     = 1'b0;
    enHeatingLevel = 1'b0;
    enOut          = 1'b1;
    step();
    check("entry_running", int'(running), 1);
    check("entry_heater", int'(heaterOn), 1);
    m_state = 0; m_k = 0; m_dur = dur; m_lvl = lvl;
    $display("run start dur=%0d lvl=%0d", dur, lvl);
  endtask

  initial begin
    int exp_beep;
    // en_dur en_lvl en_out en_rst dur lvl | tl done run heat
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 16'd5, 2'd2, 16'd5, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'd9, 2'd0, 16'd9, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b1, 16'd7, 2'd0, 16'd0, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 16'd0, 2'd0, 16'd0, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 2'd0, 16'd0, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 16'd0, 2'd0, 16'd0, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 16'd4, 2'd0, 16'd0, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 16'd0, 2'd0, 16'd0, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 16'd2, 2'd0, 16'd2, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 16'd0, 2'd0, 16'd2, 1'b0, 1'b1, 1'b1};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 16'd0, 2'd0, 16'd2, 1'b0, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 2'd0, 16'd2, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{1'b1, 1'b0, 1'b0, 1'b1, 16'd7, 2'd0, 16'd0, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 1'b0, 1'b1, 1'b0, 16'd0, 2'd0, 16'd0, 1'b0, 1'b0, 1'b0};

    reset = 1'b1; enDuration = 1'b0; enHeatingLevel = 1'b0; enOut = 1'b0;
    enEnd = 1'b0; enReset = 1'b0; inDuration = 16'd0; inHeatLevel = 2'd0;
    step();
    step();
    reset = 1'b0;
    $display("reset: tl=%0d done=%0b run=%0b heat=%0b beep=%0b",
             timeLeft, doneCount, running, heaterOn, beep);
    check("rst_timeLeft", int'(timeLeft), 0);
    check("rst_done", int'(doneCount), 0);
    check("rst_running", int'(running), 0);
    check("rst_heater", int'(heaterOn), 0);
    check("rst_beep", int'(beep), 0);

    // Vector table: loads, zero duration, ignored loads, reset priority.
    for (int i = 0; i < 14; i++) begin
      enDuration     = vecs[i].en_dur;
      enHeatingLevel = vecs[i].en_lvl;
      enOut          = vecs[i].en_out;
      enReset        = vecs[i].en_rst;
      inDuration     = vecs[i].dur;
      inHeatLevel    = vecs[i].lvl;
      step();
      $display("vec %0d: tl=%0d done=%0b run=%0b heat=%0b", i,
               timeLeft, doneCount, running, heaterOn);
      check("vec_timeLeft", int'(timeLeft), int'(vecs[i].tl));
      check("vec_done", int'(doneCount), int'(vecs[i].done));
      check("vec_running", int'(running), int'(vecs[i].run));
      check("vec_heater", int'(heaterOn), int'(vecs[i].heat));
    end
    enDuration = 1'b0; enReset = 1'b0; enOut = 1'b0;

    // Basic countdown: 3 s at level 2, then hold past expiry.
    start_run(3, 2);
    for (int i = 0; i < 35; i++) cyc(1'b1, 1'b0, 2'd0);

    // Beeper while expired with enEnd high, then silenced.
    enEnd = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
`ifdef MICROWAVE_DATAPATH_BEEP_EN
      exp_beep = ((i / 2) % 2 == 0) ? 1 : 0;
`else
      exp_beep = 0;
`endif
      $display("beep %0d: beep=%0b", i, beep);
      check("beep_pattern", int'(beep), exp_beep);
      check("beep_done_held", int'(doneCount), 1);
    end
    enEnd = 1'b0;
    step();
    check("beep_off", int'(beep), 0);
    enReset = 1'b1;
    step();
    enReset = 1'b0;
    $display("clear: done=%0b tl=%0d", doneCount, timeLeft);
    check("clear_done", int'(doneCount), 0);

    // Pause/resume: 15 run cycles, 20 paused, then resume to expiry.
    start_run(3, 2);
    for (int i = 0; i < 15; i++) cyc(1'b1, 1'b0, 2'd0);
    for (int i = 0; i < 20; i++) cyc(1'b0, 1'b0, 2'd0);
    for (int i = 0; i < 20; i++) cyc(1'b1, 1'b0, 2'd0);

    // PWM duty for levels 1, 3 and 0, changed while running.
    start_run(3, 1);
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 2'd0);
    cyc(1'b1, 1'b1, 2'd3);
    for (int i = 0; i < 7; i++) cyc(1'b1, 1'b0, 2'd0);
    cyc(1'b1, 1'b1, 2'd0);
    for (int i = 0; i < 7; i++) cyc(1'b1, 1'b0, 2'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
